// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter
// Purpose  : Up/down sequence counter with prescaler, one-shot or auto-reload
//            mode, terminal tick pulse and sticky done flag. Steps LED
//            patterns between 0 and a run-time limit latched at start.
// Revision : 1.0 - initial release
// ============================================================================
module seq_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   input  logic             dir,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             done,
   output logic             busy
);

   // A one-bit prescaler is kept even when PRESCALE is 1 so the width never
   // collapses to zero; it simply stays at 0 in that case.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] c_PRE_MAX = PW'(PRESCALE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_q,   pre_d;
   logic [WIDTH-1:0] lim_q,   lim_d;
   logic             dir_q,   dir_d;
   logic             ar_q,    ar_d;
   logic             tick_q,  tick_d;
   logic             done_q,  done_d;
   logic             busy_q,  busy_d;

   logic             w_at_term;
   logic [WIDTH-1:0] w_reload;

   // Terminal value and reload value both come from the latched run settings,
   // so live changes on limit/dir have no effect until the next start.
   assign w_at_term = dir_q ? (count_q == '0) : (count_q == lim_q);
   assign w_reload  = dir_q ? lim_q : '0;

   // Next-state logic: clear beats start, start beats enable.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pre_d   = pre_q;
      lim_d   = lim_q;
      dir_d   = dir_q;
      ar_d    = ar_q;
      tick_d  = 1'b0;
      done_d  = done_q;
      busy_d  = busy_q;

      if (clear) begin
         state_d = S_IDLE;
         count_d = '0;
         pre_d   = '0;
         done_d  = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  lim_d   = limit;
                  dir_d   = dir;
                  ar_d    = auto_reload;
                  count_d = dir ? limit : '0;
                  pre_d   = '0;
                  done_d  = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (enable) begin
                  if (pre_q == c_PRE_MAX) begin
                     pre_d = '0;
                     if (w_at_term) begin
                        tick_d  = 1'b1;
                        count_d = w_reload;
                        if (!ar_q) begin
                           state_d = S_DONE;
                           done_d  = 1'b1;
                           busy_d  = 1'b0;
                        end
                     end else if (dir_q) begin
                        count_d = count_q - 1'b1;
                     end else begin
                        count_d = count_q + 1'b1;
                     end
                  end else begin
                     pre_d = pre_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               count_d = '0;
               pre_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         pre_q   <= '0;
         lim_q   <= '0;
         dir_q   <= 1'b0;
         ar_q    <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pre_q   <= pre_d;
         lim_q   <= lim_d;
         dir_q   <= dir_d;
         ar_q    <= ar_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign done  = done_q;
   assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_counter
// Purpose  : Directed self-checking bench for seq_counter. Three instances
//            cover WIDTH=4/PRESCALE=1, WIDTH=4/PRESCALE=3 and
//            WIDTH=8/PRESCALE=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_counter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=4, PRESCALE=1
   logic       a_start = 0, a_clear = 0, a_en = 0, a_dir = 0, a_ar = 0;
   logic [3:0] a_lim = 0, a_cnt;
   logic       a_tick, a_done, a_busy;
   // Instance B: WIDTH=4, PRESCALE=3
   logic       b_start = 0, b_clear = 0, b_en = 0, b_dir = 0, b_ar = 0;
   logic [3:0] b_lim = 0, b_cnt;
   logic       b_tick, b_done, b_busy;
   // Instance C: WIDTH=8, PRESCALE=1
   logic       c_start = 0, c_clear = 0, c_en = 0, c_dir = 0, c_ar = 0;
   logic [7:0] c_lim = 0, c_cnt;
   logic       c_tick, c_done, c_busy;

   seq_counter #(.WIDTH(4), .PRESCALE(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .clear(a_clear),
      .enable(a_en), .limit(a_lim), .dir(a_dir), .auto_reload(a_ar),
      .count(a_cnt), .tick(a_tick), .done(a_done), .busy(a_busy));

   seq_counter #(.WIDTH(4), .PRESCALE(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .clear(b_clear),
      .enable(b_en), .limit(b_lim), .dir(b_dir), .auto_reload(b_ar),
      .count(b_cnt), .tick(b_tick), .done(b_done), .busy(b_busy));

   seq_counter #(.WIDTH(8), .PRESCALE(1)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .start(c_start), .clear(c_clear),
      .enable(c_en), .limit(c_lim), .dir(c_dir), .auto_reload(c_ar),
      .count(c_cnt), .tick(c_tick), .done(c_done), .busy(c_busy));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int cnt, input int tk, input int dn, input int bz);
      chk({tag, ".count"}, 32'(a_cnt), 32'(cnt));
      chk({tag, ".tick"},  32'(a_tick), 32'(tk));
      chk({tag, ".done"},  32'(a_done), 32'(dn));
      chk({tag, ".busy"},  32'(a_busy), 32'(bz));
   endtask

   initial begin
      int n;
      int ph;
      int exp_c;

      // ---------------- reset ----------------
      reset_n = 0;
      step(); step();
      chk_a("rst_a", 0, 0, 0, 0);
      chk("rst_b.count", 32'(b_cnt), 0);
      chk("rst_c.busy", 32'(c_busy), 0);
      reset_n = 1;

      // ---------------- A: up 0..9 one-shot ----------------
      a_lim = 4'd9; a_dir = 0; a_ar = 0; a_en = 1; a_start = 1;
      step();
      chk_a("a_start", 0, 0, 0, 1);
      a_start = 0;
      for (int k = 1; k <= 9; k++) begin
         if (k == 6) begin
            a_start = 1; a_lim = 4'd3;   // ignored while running
         end else begin
            a_start = 0;
         end
         step();
         chk_a($sformatf("a_up%0d", k), k, 0, 0, 1);
      end
      a_start = 0;
      step();
      chk_a("a_term", 0, 1, 1, 0);
      step();
      chk_a("a_done_hold", 0, 0, 1, 0);
      a_lim = 4'd9; a_start = 1;
      step();
      chk_a("a_rearm", 0, 0, 0, 1);
      a_start = 0;

      // ---------------- A: enable gating, limit 5 ----------------
      a_clear = 1;
      step();
      chk_a("a_clear", 0, 0, 0, 0);
      a_clear = 0;
      a_lim = 4'd5; a_start = 1;
      step();
      chk_a("a_g_start", 0, 0, 0, 1);
      a_start = 0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         a_en = ((i % 4) == 0) || ((i % 4) == 3);
         step();
         if (a_en) n++;
         if (n < 6)
            chk_a($sformatf("a_gate%0d", i), n, 0, 0, 1);
         else
            chk_a("a_gate_term", 0, 1, 1, 0);
      end
      a_en = 1;

      // ---------------- A: limit 0 ----------------
      a_lim = 4'd0; a_dir = 0; a_ar = 0; a_start = 1;
      step();
      chk_a("a_l0_start", 0, 0, 0, 1);
      a_start = 0;
      step();
      chk_a("a_l0_term", 0, 1, 1, 0);
      a_ar = 1; a_start = 1;
      step();
      chk_a("a_l0ar_start", 0, 0, 0, 1);
      a_start = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a($sformatf("a_l0ar%0d", i), 0, 1, 0, 1);
      end
      // terminal step coincides with clear: clear wins, no tick
      a_clear = 1;
      step();
      chk_a("a_term_clear", 0, 0, 0, 0);
      a_clear = 0; a_ar = 0;

      // ---------------- B: PRESCALE=3 down auto-reload ----------------
      b_lim = 4'd2; b_dir = 1; b_ar = 1; b_en = 1; b_start = 1;
      step();
      chk("b_start.count", 32'(b_cnt), 2);
      chk("b_start.busy", 32'(b_busy), 1);
      b_start = 0;
      for (int j = 1; j <= 27; j++) begin
         if (j == 5) b_lim = 4'd5;    // no effect until next start
         step();
         ph = j % 9;
         exp_c = (ph == 0) ? 2 : 2 - (ph / 3);
         chk($sformatf("b_cnt%0d", j), 32'(b_cnt), 32'(exp_c));
         chk($sformatf("b_tick%0d", j), 32'(b_tick), (ph == 0) ? 1 : 0);
         chk($sformatf("b_busy%0d", j), 32'(b_busy), 1);
      end
      b_clear = 1;
      step();
      chk("b_clear.busy", 32'(b_busy), 0);
      b_clear = 0;

      // ---------------- C: WIDTH=8, limit 255 ----------------
      c_lim = 8'd255; c_dir = 0; c_ar = 0; c_en = 1; c_start = 1;
      step();
      chk("c_start.count", 32'(c_cnt), 0);
      c_start = 0;
      for (int k = 1; k <= 255; k++) begin
         step();
         chk($sformatf("c_up%0d", k), 32'(c_cnt), 32'(k));
         chk($sformatf("c_tick%0d", k), 32'(c_tick), 0);
      end
      step();
      chk("c_term.count", 32'(c_cnt), 0);
      chk("c_term.tick", 32'(c_tick), 1);
      chk("c_term.done", 32'(c_done), 1);
      chk("c_term.busy", 32'(c_busy), 0);

      // ---------------- A: clear with start at count 4, reset at 7 ----------------
      a_lim = 4'd9; a_dir = 0; a_ar = 0; a_en = 1; a_start = 1;
      step();
      a_start = 0;
      for (int k = 1; k <= 4; k++) step();
      chk_a("a_at4", 4, 0, 0, 1);
      a_clear = 1; a_start = 1;
      step();
      chk_a("a_clr_start", 0, 0, 0, 0);
      a_clear = 0; a_start = 0;
      step();
      chk_a("a_idle_hold", 0, 0, 0, 0);
      a_start = 1;
      step();
      a_start = 0;
      for (int k = 1; k <= 7; k++) step();
      chk_a("a_at7", 7, 0, 0, 1);
      reset_n = 0;
      step();
      chk_a("a_midrst", 0, 0, 0, 0);
      reset_n = 1;
      step();
      chk_a("a_post_rst", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
